// File: rtl/cmp_seq_if.sv
// Operand/result handshake bundle for the sequential comparator.
// master = producer/consumer side, slave = comparator side.
interface cmp_seq_if #(
    parameter int LEN = 16
);
    logic           in_valid;
    logic           in_ready;
    logic [LEN-1:0] a;
    logic [LEN-1:0] b;
    logic [1:0]     mode;
    logic           out_valid;
    logic           out_ready;
    logic           eq;
    logic           gt;
    logic           lt;

    modport master (
        output in_valid, a, b, mode, out_ready,
        input  in_ready, out_valid, eq, gt, lt
    );

    modport slave (
        input  in_valid, a, b, mode, out_ready,
        output in_ready, out_valid, eq, gt, lt
    );
endinterface

// File: rtl/cmp_seq.sv
// Multi-cycle MSB-first comparator: CHUNK bits per cycle, four signedness modes,
// valid/ready on both operand and result sides.
module cmp_seq #(
    parameter int LEN   = 16,
    parameter int CHUNK = 4,
    parameter int EARLY = 1
) (
    input logic    clk,
    input logic    rst_n,
    cmp_seq_if.slave bus
);
    localparam int NCH  = LEN / CHUNK;
    localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    if (LEN < 2 || CHUNK < 1 || (LEN % CHUNK) != 0) begin : g_bad_params
        $error("cmp_seq: LEN must be >= 2 and a multiple of CHUNK");
    end

    logic [1:0]      r_state;
    logic [IDXW-1:0] r_idx;
    logic            r_decided;
    logic            r_gt;
    logic [LEN-1:0]  r_a;
    logic [LEN-1:0]  r_b;

    logic             w_accept;
    logic             w_a_signed;
    logic             w_b_signed;
    logic             w_ea;
    logic             w_eb;
    logic [CHUNK-1:0] w_a_chunks [NCH];
    logic [CHUNK-1:0] w_b_chunks [NCH];
    logic [CHUNK-1:0] w_ca;
    logic [CHUNK-1:0] w_cb;
    logic             w_chunk_ne;
    logic             w_chunk_gt;
    logic             w_early_stop;
    logic             w_done;

    assign w_a_signed = (bus.mode == 2'b01) || (bus.mode == 2'b10);
    assign w_b_signed = (bus.mode == 2'b01) || (bus.mode == 2'b11);
    assign w_ea       = w_a_signed & bus.a[LEN-1];
    assign w_eb       = w_b_signed & bus.b[LEN-1];

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_chunk
            assign w_a_chunks[gi] = r_a[gi*CHUNK +: CHUNK];
            assign w_b_chunks[gi] = r_b[gi*CHUNK +: CHUNK];
        end
    endgenerate

    // Only a CHUNK-wide compare exists; the wide operands are just muxed into it.
    assign w_ca       = w_a_chunks[r_idx];
    assign w_cb       = w_b_chunks[r_idx];
    assign w_chunk_ne = (w_ca != w_cb);
    assign w_chunk_gt = (w_ca > w_cb);

    assign w_early_stop = (EARLY != 0) && (r_decided || w_chunk_ne);

    assign w_done        = (r_state == ST_DONE);
    assign bus.in_ready  = rst_n && (r_state == ST_IDLE);
    assign bus.out_valid = w_done;
    assign bus.eq        = w_done & ~r_decided;
    assign bus.gt        = w_done &  r_decided &  r_gt;
    assign bus.lt        = w_done &  r_decided & ~r_gt;
    assign w_accept      = bus.in_valid & bus.in_ready;

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_a <= bus.a;
            r_b <= bus.b;
        end
    end

    // A sign-decided operation still passes through one SCAN cycle, which gives it
    // the same one-cycle latency as a difference found in the top chunk.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_idx     <= '0;
            r_decided <= 1'b0;
            r_gt      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_idx     <= IDXW'(NCH - 1);
                        r_decided <= (w_ea != w_eb);
                        r_gt      <= w_eb;
                        r_state   <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (!r_decided && w_chunk_ne) begin
                        r_decided <= 1'b1;
                        r_gt      <= w_chunk_gt;
                    end
                    if (r_idx == '0 || w_early_stop) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_idx <= r_idx - 1'b1;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule
